// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-organised data memory: alignment/range checks,
// sub-word extraction with sign/zero extension, and read-modify-write for sub-word stores.
module mem_access_unit #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] LIMIT = 32'(MEM_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t      state_q;
  logic        wr_q;
  logic        uns_q;
  logic        err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] buf_q;
  logic [31:0] rdata_q;
  logic [31:0] ld_d;
  logic [31:0] mwdata_d;

  function automatic logic req_error(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
           (sz == 2'b10 && a[1:0] != 2'b00) || (a >= LIMIT);
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] a, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return u ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return u ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [1:0] a);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) begin
      r[{a, 3'b000} +: 8] = d[7:0];
    end else if (a[1]) begin
      r[31:16] = d[15:0];
    end else begin
      r[15:0] = d[15:0];
    end
    return r;
  endfunction

  assign ld_d     = load_extract(mem_rdata, size_q, addr_q[1:0], uns_q);
  assign mwdata_d = (size_q == 2'b10) ? wdata_q : store_merge(buf_q, wdata_q, size_q, addr_q[1:0]);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      buf_q   <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            wr_q    <= wr;
            uns_q   <= unsigned_ld;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
            err_q   <= req_error(size, addr);
            // Only a full-word store skips the read; sub-word stores need the old word.
            if (req_error(size, addr)) begin
              state_q <= S_DONE;
            end else if (!wr || size != 2'b10) begin
              state_q <= S_READ;
            end else begin
              state_q <= S_WRITE;
            end
          end
        end
        S_READ: begin
          buf_q <= mem_rdata;
          if (!wr_q) begin
            rdata_q <= ld_d;
            state_q <= S_DONE;
          end else begin
            state_q <= S_WRITE;
          end
        end
        S_WRITE: state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes gated by reset so a reset edge can never commit a write.
  assign ready     = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_DONE) && err_q;
  assign rdata     = rdata_q;
  assign mem_read  = (state_q == S_READ) && reset_n;
  assign mem_write = (state_q == S_WRITE) && reset_n;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = mwdata_d;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-level memory model, per-cycle output comparison,
// directed scenarios with literal expectations and a randomized transaction mix.
module tb_mem_access_unit;

  logic        clock;
  logic        reset_n;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_access_unit #(.MEM_BYTES(1024)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .wr(wr), .size(size),
    .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata), .ready(ready),
    .done(done), .err(err), .rdata(rdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Data memory the unit talks to: combinational read, write on the rising edge.
  logic [31:0] mem [256] = '{default: 32'h0};
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clock) begin
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  // Reference model: byte-addressed memory and one transaction in flight.
  logic [7:0]  gm [1024] = '{default: 8'h00};
  logic        m_busy = 1'b0;
  int          m_ph = 0;
  int          m_lat = 0;
  int          n_acc = 0;
  logic        t_err = 1'b0;
  logic        t_wr = 1'b0;
  logic [1:0]  t_size = 2'b00;
  logic [31:0] t_addr = 32'h0;
  logic [31:0] t_new = 32'h0;
  logic [31:0] t_ld = 32'h0;
  logic [31:0] e_rdata = 32'h0;

  always @(posedge clock) begin
    logic [7:0] wb [4];
    logic [7:0] b;
    logic [15:0] h;
    int a, nb;
    if (!reset_n) begin
      m_busy  = 1'b0;
      e_rdata = 32'h0;
    end else if (m_busy) begin
      if (m_ph == m_lat) begin
        m_busy = 1'b0;
        if (t_wr && !t_err)
          for (int k = 0; k < 4; k++) gm[int'(t_addr[9:2]) * 4 + k] = t_new[8*k +: 8];
      end else begin
        m_ph++;
        if (m_ph == m_lat && !t_wr && !t_err) e_rdata = t_ld;
      end
    end else if (req) begin
      n_acc++;
      t_wr   = wr;
      t_size = size;
      t_addr = addr;
      t_err  = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
               (size == 2'd2 && addr % 4 != 0) || (addr >= 32'd1024);
      t_ld   = 32'h0;
      t_new  = 32'h0;
      if (!t_err) begin
        a = int'(addr);
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int k = 0; k < 4; k++) wb[k] = gm[(a / 4) * 4 + k];
        for (int k = 0; k < nb; k++) wb[a % 4 + k] = wdata[8*k +: 8];
        t_new = {wb[3], wb[2], wb[1], wb[0]};
        b = gm[a];
        h = {gm[a + 1 - (a % 2)], gm[a - (a % 2)]};
        if (size == 2'd0)      t_ld = unsigned_ld ? {24'h0, b} : {{24{b[7]}}, b};
        else if (size == 2'd1) t_ld = unsigned_ld ? {16'h0, h} : {{16{h[15]}}, h};
        else                   t_ld = {gm[a + 3], gm[a + 2], gm[a + 1], gm[a]};
      end
      m_lat  = t_err ? 1 : (!wr || size == 2'd2) ? 2 : 3;
      m_ph   = 1;
      m_busy = 1'b1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n_rd = 0;
  int n_wr = 0;
  int n_errp = 0;
  int n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle_check();
    logic xd, xr, xw;
    if (mem_read === 1'b1) n_rd++;
    if (mem_write === 1'b1) n_wr++;
    if (!reset_n) begin
      chk("rst_mem_read", {31'h0, mem_read}, 32'h0);
      chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
      return;
    end
    xd = m_busy && m_ph == m_lat;
    xr = m_busy && !t_err && m_ph == 1 && (!t_wr || t_size != 2'd2);
    xw = m_busy && !t_err && t_wr && m_ph == ((t_size == 2'd2) ? 1 : 2);
    if (done === 1'b1) n_done++;
    if (done === 1'b1 && err === 1'b1) n_errp++;
    chk("ready", {31'h0, ready}, {31'h0, !m_busy});
    chk("done", {31'h0, done}, {31'h0, xd});
    if (xd) chk("err", {31'h0, err}, {31'h0, t_err});
    chk("rdata", rdata, e_rdata);
    chk("mem_read", {31'h0, mem_read}, {31'h0, xr});
    chk("mem_write", {31'h0, mem_write}, {31'h0, xw});
    if (xr || xw) chk("mem_addr", mem_addr, {t_addr[31:2], 2'b00});
    if (xw) chk("mem_wdata", mem_wdata, t_new);
  endtask

  task automatic tick();
    @(negedge clock);
    cycle_check();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int g;
    g = 0;
    while (m_busy && g < budget) begin
      tick();
      g++;
    end
    if (m_busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: access still busy after %0d cycles", budget);
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    wait_idle(20);
    req = 1'b1; wr = w; size = s; unsigned_ld = u; addr = a; wdata = d;
    tick();
    req = 1'b0;
    wait_idle(10);
    if (a < 32'd1024)
      chk("mem_word", mem[a[9:2]],
          {gm[{a[9:2], 2'd3}], gm[{a[9:2], 2'd2}], gm[{a[9:2], 2'd1}], gm[{a[9:2], 2'd0}]});
  endtask

  initial begin
    int rd0, wr0, er0, dn0;
    logic [31:0] ra;
    logic [1:0]  rs;
    reset_n = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00;
    unsigned_ld = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (3) tick();
    reset_n = 1'b1;
    chk("reset_ready", {31'h0, ready}, 32'h1);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_err", {31'h0, err}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    tick();

    wr0 = n_wr;
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("sw_word", mem[4], 32'hDEADBEEF);
    chk("sw_write_cycles", n_wr - wr0, 1);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("lw_rdata", rdata, 32'hDEADBEEF);

    rd0 = n_rd; wr0 = n_wr;
    issue(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000005A);
    chk("sb_word", mem[4], 32'hDE5ABEEF);
    chk("sb_read_cycles", n_rd - rd0, 1);
    chk("sb_write_cycles", n_wr - wr0, 1);

    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    chk("lb_13", rdata, 32'hFFFFFFDE);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    chk("lbu_13", rdata, 32'h000000DE);
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    chk("lh_12", rdata, 32'hFFFFDE5A);
    issue(1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
    chk("lhu_10", rdata, 32'h0000BEEF);

    rd0 = n_rd; wr0 = n_wr; er0 = n_errp;
    issue(1'b0, 2'd2, 1'b0, 32'h11, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h13, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D);
    issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
    chk("err_pulses", n_errp - er0, 4);
    chk("err_no_read", n_rd - rd0, 0);
    chk("err_no_write", n_wr - wr0, 0);
    chk("err_rdata_kept", rdata, 32'h0000BEEF);
    chk("err_mem_kept", mem[4], 32'hDE5ABEEF);

    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h0);
    req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h20; wdata = 32'h12345678;
    tick();
    req = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("abort_ready", {31'h0, ready}, 32'h1);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    tick();
    chk("abort_mem", mem[8], 32'h0);

    rd0 = n_rd; dn0 = n_done;
    req = 1'b1; wr = 1'b0; size = 2'd2; unsigned_ld = 1'b0; addr = 32'h10;
    repeat (6) tick();
    req = 1'b0;
    wait_idle(10);
    chk("held_req_reads", n_rd - rd0, 2);
    chk("held_req_dones", n_done - dn0, 2);
    chk("held_req_rdata", rdata, 32'hDE5ABEEF);

    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       ra = $urandom;
        1:       ra = $urandom_range(1016, 1031);
        default: ra = $urandom_range(0, 63);
      endcase
      if (rs != 2'd3 && $urandom_range(0, 9) < 7) ra = ra & ~((32'd1 << rs) - 32'd1);
      issue(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom);
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the single-cycle datapath's memory stage and the word-organised data memory. Accepts one byte, halfword or word request, checks alignment and range, and drives the memory's read/write strobes, word address and write data. Sub-word stores become a read-modify-write sequence. Loads return sign- or zero-extended results. Multi-cycle: the core stalls while `ready` is low.

## Interface
- `MEM_BYTES`, 1024: size of the data memory in bytes (256 words); accesses at or above this are range errors.

- `clock`  in  1  system clock, all state on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `req`  in  1  request strobe, sampled only while `ready`=1
- `wr`  in  1  1 = store, 0 = load
- `size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- `unsigned_ld`  in  1  1 = zero-extend sub-word load, 0 = sign-extend
- `addr`  in  32  byte address
- `wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- `ready`  out  1  unit idle, can accept `req`
- `done`  out  1  one-cycle pulse: access complete
- `err`  out  1  valid with `done`: misaligned, out-of-range or illegal size; no memory access performed
- `rdata`  out  32  load result, held until next load completes
- `mem_read`  out  1  to memory MemRead
- `mem_write`  out  1  to memory MemWrite
- `mem_addr`  out  32  to memory address, always `{addr[31:2],2'b00}` of the latched request
- `mem_wdata`  out  32  to memory writeData
- `mem_rdata`  in  32  from memory readData (combinational read)

## Operation
- States: IDLE, READ, WRITE, DONE. `ready` = (state==IDLE).
- In IDLE with `req`=1: latch `wr,size,unsigned_ld,addr,wdata`; evaluate error:
  - `size`=11 → error; `size`=01 with `addr[0]`=1 → error; `size`=10 with `addr[1:0]`≠0 → error; `addr` ≥ `MEM_BYTES` → error.
- Transitions from IDLE on accepted req:
  - error → DONE, `err` set.
  - load (any size) → READ.
  - store word → WRITE.
  - store byte/half → READ.
- READ: `mem_read`=1. At the closing edge, capture `mem_rdata` into the word buffer. For a load, extract the lane, extend it, write it to `rdata`, and go to DONE. For a store, go to WRITE.
- WRITE: `mem_write`=1; the memory commits at the closing edge; next state is DONE.
  - Word store: `mem_wdata`=`wdata`.
  - Sub-word store: `mem_wdata` = buffer with the target lane replaced.
- DONE: `done`=1 for one cycle; `err` reflects the request; next state is IDLE.
- Lanes are little-endian:
  - Byte k = bits [8k+7:8k], selected by `addr[1:0]`.
  - Halfword at `addr[1]`=0 is [15:0]; at `addr[1]`=1 it is [31:16].
- Extension: sign-extend from bit 7/15 unless `unsigned_ld`=1.
- `mem_read`/`mem_write` are decoded from state and ANDed with `reset_n`, so no memory write occurs on a reset edge.
- `req` while not IDLE is ignored (not queued).
- An error never asserts `mem_read` or `mem_write`, and leaves `rdata` unchanged.

## Timing
- Reset (`reset_n`=0 at a rising edge):
  - State → IDLE; `done`,`err`=0; `rdata`=0; latched request and buffer = 0.
  - `mem_read`,`mem_write`=0 during reset.
  - Mid-operation reset aborts the access; a WRITE in progress is not committed.
- Latency is measured from the accept edge (E0) to the cycle in which `done`=1:
  - Error: 1 cycle (DONE during E0→E1).
  - Load: READ during E0→E1; `done` and updated `rdata` during E1→E2.
  - Store word: WRITE during E0→E1; memory updated at E1; `done` during E1→E2.
  - Sub-word store: READ, WRITE, then DONE in the third cycle; memory updated at E2.
- `ready`=1 again in the cycle after `done`; back-to-back issue throughput is one access per latency+1 cycles.
- `mem_addr`/`mem_wdata` are stable for the whole READ/WRITE cycle.

## Test plan
- Store word 0xDEADBEEF @0x10, then load word @0x10: `mem_write` asserted for exactly 1 cycle; `rdata`=0xDEADBEEF; `done` 2 cycles after each accept; `err`=0.
- With word @0x10 = 0xDEADBEEF, store byte 0x5A @0x12 (`size`=00): memory word becomes 0xDE5ABEEF; READ then WRITE observed; `done` in the 3rd cycle.
- With word @0x10 = 0xDE5ABEEF:
  - lb @0x13 → 0xFFFFFFDE; lbu @0x13 → 0x000000DE; lh @0x12 → 0xFFFFDE5A; lhu @0x10 → 0x0000BEEF.
- Errors: lw @0x11, lh @0x13, sw @0x400 (`MEM_BYTES`=1024), and `size`=11 each produce `done`&`err` 1 cycle after accept, with `mem_read`/`mem_write` never high, memory unchanged and `rdata` unchanged.
- Drop `reset_n` during the WRITE cycle of sw 0x12345678 @0x20 (previous content 0): word @0x20 stays 0; `ready`=1, `done`=0, `rdata`=0 the cycle after reset.
- Hold `req`=1 continuously through a load: exactly one access is performed and a second is accepted only after `ready` returns high.
